char_rx_ctrl: RTL and testbench
===============================

CHAR_RX_CTRL -- requirements
Module: char_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning receive FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter THRESH, default 4, meaning FIFO level at or above which the level interrupt asserts (1..DEPTH).
REQ-003 SHALL have parameter TIMEOUT, default 4800, meaning idle cycles with non-empty FIFO before the timeout interrupt asserts.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port char_in  input  8  character from terminal source; valid while char_strobe high.
REQ-007 SHALL have port char_strobe  input  1  character-valid strobe from terminal source.
REQ-008 SHALL have ports psel, penable, pwrite  input  1 each  APB control.
REQ-009 SHALL have port paddr  input  4  byte address; bits[1:0] ignored.
REQ-010 SHALL have port pwdata  input  32  APB write data.
REQ-011 SHALL have port prdata  output  32  APB read data, combinational, valid in access phase.
REQ-012 SHALL have port pready  output  1  tied 1 (zero wait states).
REQ-013 SHALL have port irq  output  1  registered, level interrupt to CPU.

Function
REQ-014 SHALL register char_strobe into strobe_d each cycle; push condition = char_strobe & !strobe_d & EN.
REQ-015 SHALL write char_in into the FIFO tail on a push cycle; the entry SHALL be visible in STATUS and DATA from the next cycle.
REQ-016 Access phase = psel & penable; setup phase (psel & !penable) SHALL have no side effects.
REQ-017 Register 0x0 DATA (RO): prdata = {24'b0, head}; read access SHALL pop one entry; read when empty SHALL return 0 and change nothing.
REQ-018 Register 0x4 STATUS: bit0 not_empty, bit1 full, bit2 overflow (W1C), bit3 timeout flag (RO), bits[14:8] count; other bits 0.
REQ-019 Register 0x8 CTRL (RW): bit0 EN, bit1 IRQ_EN; writing bit2 = 1 SHALL flush the FIFO (self-clearing, reads 0).
REQ-020 Register 0xC SHALL read 0; writes to 0x0 and 0xC SHALL be ignored.
REQ-021 Push and pop in the same cycle SHALL both succeed, count unchanged, including when full (no overflow).
REQ-022 Push when full without pop SHALL drop the character, set overflow, leave FIFO unchanged.
REQ-023 Flush SHALL empty FIFO (pointers and count 0), clear timeout flag; flush wins over a same-cycle push or pop (character discarded, no overflow set).
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH with width log2(DEPTH)+1.
REQ-025 Idle counter SHALL reset to 0 on push, pop or flush, increment while FIFO non-empty, hold at 0 while empty.
REQ-026 Timeout flag SHALL set when idle counter reaches TIMEOUT-1 and clear on pop or flush.
REQ-027 irq SHALL be registered as IRQ_EN & ((count >= THRESH) | timeout | overflow), one-cycle latency from the causing state.
REQ-028 With EN = 0 strobes SHALL be ignored; FIFO contents and reads SHALL remain available.

Reset
REQ-029 On resetn low: FIFO empty, pointers/count 0, strobe_d 0, overflow 0, timeout 0, idle counter 0, EN 0, IRQ_EN 0, irq 0.
REQ-030 Reset mid-operation SHALL discard all buffered characters; first push accepted only after EN is rewritten to 1.

Verification
REQ-031 EN=1; strobe one cycle with char 0x41 -> next cycle STATUS = 0x101; DATA read returns 0x41; STATUS then 0x000.
REQ-032 Strobe held high 5 cycles with 0x42 -> exactly one entry pushed (count 1).
REQ-033 DEPTH=8: push 9 characters without reads -> count 8, full=1, overflow=1; reads return first 8 in order; W1C 0x4 bit2 clears overflow.
REQ-034 FIFO full, push and DATA read in same cycle -> count stays 8, overflow stays 0, newest char at tail.
REQ-035 IRQ_EN=1, THRESH=4: 3 pushes -> irq 0; 4th push -> irq 1 two cycles after that strobe; one read -> irq 0 next cycle.
REQ-036 IRQ_EN=1, 1 char pushed, no reads for TIMEOUT cycles -> timeout bit set, irq 1; flush via CTRL bit2 -> count 0, timeout 0, irq 0.

Source files
------------

// File: rtl/char_rx_ctrl.sv
// Character receive controller: edge-detected strobe pushes characters into a FIFO
// drained over APB, with level, timeout and overflow interrupt sources.
module char_rx_ctrl #(
    parameter int DEPTH   = 8,
    parameter int THRESH  = 4,
    parameter int TIMEOUT = 4800
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  char_in,
    input  logic        char_strobe,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [IW-1:0] idle_reg;
    logic          strobe_d_reg;
    logic          overflow_reg;
    logic          timeout_reg;
    logic          en_reg;
    logic          irq_en_reg;
    logic          irq_reg;

    logic          access;
    logic          rd_access;
    logic          wr_access;
    logic [1:0]    reg_sel;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          flush;
    logic          push_ok;
    logic          unused_bits;

    assign access    = psel & penable;
    assign rd_access = access & ~pwrite;
    assign wr_access = access & pwrite;
    assign reg_sel   = paddr[3:2];

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    assign push  = char_strobe & ~strobe_d_reg & en_reg;
    assign pop   = rd_access & (reg_sel == 2'd0) & ~empty;
    assign flush = wr_access & (reg_sel == 2'd2) & pwdata[2];
    // A full FIFO still accepts a push when the same cycle pops the head.
    assign push_ok = push & (~full | pop) & ~flush;

    assign pready = 1'b1;
    assign irq    = irq_reg;
    assign unused_bits = &{1'b0, paddr[1:0], pwdata[31:3]};

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= char_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            strobe_d_reg <= 1'b0;
        end else begin
            strobe_d_reg <= char_strobe;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
                count_reg <= count_next;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_reg       <= 1'b0;
            irq_en_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_access && reg_sel == 2'd2) begin
                en_reg     <= pwdata[0];
                irq_en_reg <= pwdata[1];
            end
            // A new overflow event takes priority over a same-cycle clear.
            if (push && full && !pop && !flush) begin
                overflow_reg <= 1'b1;
            end else if (wr_access && reg_sel == 2'd1 && pwdata[2]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (push || pop || flush) begin
                idle_reg <= '0;
            end else if (!empty && idle_reg != IW'(TIMEOUT - 1)) begin
                idle_reg <= idle_reg + IW'(1);
            end

            if (pop || flush) begin
                timeout_reg <= 1'b0;
            end else if (!empty && idle_reg == IW'(TIMEOUT - 1)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_en_reg & ((count_reg >= CW'(THRESH)) | timeout_reg | overflow_reg);
        end
    end

    always_comb begin
        prdata = '0;
        case (reg_sel)
            2'd0: prdata = empty ? 32'd0 : {24'd0, mem[rd_ptr_reg]};
            2'd1: prdata = {17'd0, 7'(count_reg), 4'd0, timeout_reg, overflow_reg, full, ~empty};
            2'd2: prdata = {30'd0, irq_en_reg, en_reg};
            default: prdata = '0;
        endcase
    end

endmodule

// File: tb/tb_char_rx_ctrl.sv
// Scoreboard bench for char_rx_ctrl: accepted characters are queued on strobe
// and compared in order against DATA reads.
module tb_char_rx_ctrl;

    localparam int DEPTH   = 8;
    localparam int THRESH  = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_strobe = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = 4'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready;
    logic        irq;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         en_model = 1'b0;

    char_rx_ctrl #(.DEPTH(DEPTH), .THRESH(THRESH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .char_in(char_in), .char_strobe(char_strobe),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(negedge clk); penable = 1;
        @(negedge clk); psel = 0; penable = 0; pwrite = 0;
        if (a[3:2] == 2'd2) begin
            en_model = d[0];
            if (d[2]) exp_q.delete();
        end
        $display("apb write addr=0x%0h data=0x%08h", a, d);
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(negedge clk); penable = 1;
        #1 d = prdata;
        @(negedge clk); psel = 0; penable = 0;
        $display("apb read  addr=0x%0h data=0x%08h", a, d);
    endtask

    task automatic send_char(input logic [7:0] c);
        @(negedge clk); char_in = c; char_strobe = 1;
        @(negedge clk); char_strobe = 0;
        if (en_model && exp_q.size() < DEPTH) exp_q.push_back(c);
        $display("strobe char=0x%02h queued=%0d", c, exp_q.size());
    endtask

    task automatic drain(input string name, input int n);
        logic [31:0] r;
        logic [7:0]  e;
        for (int i = 0; i < n; i++) begin
            apb_read(4'h0, r);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            checks++;
            if (r !== {24'd0, e}) begin
                errors++;
                $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, i, r, {24'd0, e});
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        repeat (3) @(negedge clk);
        checks++;
        if (irq !== 1'b0 || pready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got irq=%b pready=%b expected irq=0 pready=1", irq, pready);
        end
        resetn = 1;
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got 0x%08h expected 0x00000000", r); end
        apb_read(4'h8, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got 0x%08h expected 0x00000000", r); end
        apb_read(4'h0, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL empty_data: got 0x%08h expected 0x00000000", r); end
        apb_write(4'hC, 32'hFFFF_FFFF);
        apb_read(4'hC, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reg_c: got 0x%08h expected 0x00000000", r); end
        apb_read(4'h8, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL ctrl_after_c_write: got 0x%08h expected 0x00000000", r); end
    endtask

    task automatic test_single();
        logic [31:0] r;
        apb_write(4'h8, 32'h1);
        send_char(8'h41);
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h101) begin errors++; $display("FAIL single_status: got 0x%08h expected 0x00000101", r); end
        drain("single_data", 1);
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL single_status_after: got 0x%08h expected 0x00000000", r); end
    endtask

    task automatic test_held_strobe();
        logic [31:0] r;
        @(negedge clk); char_in = 8'h42; char_strobe = 1;
        repeat (5) @(negedge clk);
        char_strobe = 0;
        exp_q.push_back(8'h42);
        $display("held strobe char=0x42 for 5 cycles");
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h101) begin errors++; $display("FAIL held_status: got 0x%08h expected 0x00000101", r); end
        drain("held_data", 1);
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        for (int i = 0; i < DEPTH + 1; i++) send_char(8'h60 + 8'(i));
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h807) begin errors++; $display("FAIL ovf_status: got 0x%08h expected 0x00000807", r); end
        drain("ovf_data", DEPTH);
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h004) begin errors++; $display("FAIL ovf_sticky: got 0x%08h expected 0x00000004", r); end
        apb_write(4'h4, 32'h4);
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL ovf_w1c: got 0x%08h expected 0x00000000", r); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] r;
        logic [7:0]  e;
        for (int i = 0; i < DEPTH; i++) send_char(8'hA0 + 8'(i));
        @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = 4'h0;
        @(negedge clk); penable = 1; char_in = 8'h99; char_strobe = 1;
        #1 r = prdata;
        @(negedge clk); psel = 0; penable = 0; char_strobe = 0;
        e = exp_q.pop_front();
        exp_q.push_back(8'h99);
        $display("simultaneous push 0x99 and read data=0x%08h", r);
        checks++;
        if (r !== {24'd0, e}) begin errors++; $display("FAIL pp_data: got 0x%08h expected 0x%08h", r, {24'd0, e}); end
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h803) begin errors++; $display("FAIL pp_status: got 0x%08h expected 0x00000803", r); end
        drain("pp_drain", DEPTH);
    endtask

    task automatic test_enable_off();
        logic [31:0] r;
        send_char(8'h55);
        apb_write(4'h8, 32'h0);
        send_char(8'h66);
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h101) begin errors++; $display("FAIL en_off_status: got 0x%08h expected 0x00000101", r); end
        drain("en_off_data", 1);
    endtask

    task automatic test_irq_thresh();
        apb_write(4'h8, 32'h3);
        for (int i = 0; i < THRESH - 1; i++) send_char(8'h30 + 8'(i));
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_below: got %b expected 0", irq); end
        send_char(8'h3F);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_thresh: got %b expected 1", irq); end
        drain("irq_read", 1);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_read: got %b expected 0", irq); end
        drain("irq_drain", THRESH - 1);
    endtask

    task automatic test_timeout();
        logic [31:0] r;
        send_char(8'h77);
        repeat (TIMEOUT) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL timeout_irq: got %b expected 1", irq); end
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h109) begin errors++; $display("FAIL timeout_status: got 0x%08h expected 0x00000109", r); end
        apb_write(4'h8, 32'h7);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq: got %b expected 0", irq); end
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL flush_status: got 0x%08h expected 0x00000000", r); end
        apb_read(4'h8, r);
        checks++;
        if (r !== 32'h3) begin errors++; $display("FAIL flush_ctrl: got 0x%08h expected 0x00000003", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        send_char(8'h11);
        send_char(8'h22);
        @(negedge clk); resetn = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        exp_q.delete();
        en_model = 0;
        $display("reset pulse mid-operation");
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL rst_mid_status: got 0x%08h expected 0x00000000", r); end
        send_char(8'h33);
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL rst_mid_en0: got 0x%08h expected 0x00000000", r); end
        apb_write(4'h8, 32'h1);
        send_char(8'h44);
        apb_read(4'h4, r);
        checks++;
        if (r !== 32'h101) begin errors++; $display("FAIL rst_mid_en1: got 0x%08h expected 0x00000101", r); end
        drain("rst_mid_data", 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_held_strobe();
        test_overflow();
        test_full_push_pop();
        test_enable_off();
        test_irq_thresh();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
